// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - two-master (instruction/data) arbiter onto one 32-bit SDRAM bridge port
// Optional ARB_ROUND_ROBIN_EN: ties alternate between masters; otherwise D always wins ties.
module sdram_arbiter #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_cs,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  input  logic                  i_wr_en,
  input  logic [3:0]            i_bytesel,
  output logic [31:0]           i_rdata,
  output logic                  i_compl,
  input  logic                  d_cs,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wdata,
  input  logic                  d_wr_en,
  input  logic [3:0]            d_bytesel,
  output logic [31:0]           d_rdata,
  output logic                  d_compl,
  output logic                  m_cs,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [31:0]           m_wdata,
  output logic                  m_wr_en,
  output logic [3:0]            m_bytesel,
  input  logic [31:0]           m_rdata,
  input  logic                  m_compl
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_t;

  state_t r_state;
  state_t w_next;
  logic   w_i_req;
  logic   w_d_req;
  logic   w_pick_i;
  logic   w_grant_i;
  logic   w_grant_d;
  logic   w_done_i;
  logic   w_done_d;

  assign w_i_req = i_cs && (|i_bytesel);
  assign w_d_req = d_cs && (|d_bytesel);

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_d;

  // On a tie, favour whichever master did not win the previous grant.
  assign w_pick_i = w_i_req && (!w_d_req || r_last_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_d <= 1'b1;
    end else if (w_grant_i || w_grant_d) begin
      r_last_d <= w_grant_d;
    end
  end
`else
  assign w_pick_i = w_i_req && !w_d_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    w_done_i  = 1'b0;
    w_done_d  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_i) begin
          w_next    = GRANT_I;
          w_grant_i = 1'b1;
        end else if (w_d_req) begin
          w_next    = GRANT_D;
          w_grant_d = 1'b1;
        end
      end
      GRANT_I: begin
        if (m_compl) begin
          w_next   = RELEASE;
          w_done_i = 1'b1;
        end
      end
      GRANT_D: begin
        if (m_compl) begin
          w_next   = RELEASE;
          w_done_d = 1'b1;
        end
      end
      RELEASE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request fields are latched at grant and held; release drops cs/bytesel so the bridge idles cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cs      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      m_wr_en   <= 1'b0;
      m_bytesel <= 4'b0000;
      i_compl   <= 1'b0;
      d_compl   <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      i_compl <= w_done_i;
      d_compl <= w_done_d;
      if (w_grant_i) begin
        m_cs      <= 1'b1;
        m_addr    <= i_addr;
        m_wdata   <= i_wdata;
        m_wr_en   <= i_wr_en;
        m_bytesel <= i_bytesel;
      end else if (w_grant_d) begin
        m_cs      <= 1'b1;
        m_addr    <= d_addr;
        m_wdata   <= d_wdata;
        m_wr_en   <= d_wr_en;
        m_bytesel <= d_bytesel;
      end else if (w_done_i || w_done_d) begin
        m_cs      <= 1'b0;
        m_bytesel <= 4'b0000;
      end
      if (w_done_i && !m_wr_en) begin
        i_rdata <= m_rdata;
      end
      if (w_done_d && !m_wr_en) begin
        d_rdata <= m_rdata;
      end
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - directed and randomized checks of sdram_arbiter against a transaction-level model
module tb_sdram_arbiter;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_cs, d_cs, i_wr_en, d_wr_en, m_compl;
  logic [AW-1:0] i_addr, d_addr;
  logic [31:0]   i_wdata, d_wdata, m_rdata;
  logic [3:0]    i_bytesel, d_bytesel;
  logic [31:0]   i_rdata, d_rdata;
  logic          i_compl, d_compl;
  logic          m_cs, m_wr_en;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic [3:0]    m_bytesel;

  int errors = 0;
  int checks = 0;

  bit          last_d = 1'b1;
  logic [31:0] exp_irdata = '0;
  logic [31:0] exp_drdata = '0;

  always #5 clk = ~clk;

  sdram_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cs(i_cs), .i_addr(i_addr), .i_wdata(i_wdata), .i_wr_en(i_wr_en),
    .i_bytesel(i_bytesel), .i_rdata(i_rdata), .i_compl(i_compl),
    .d_cs(d_cs), .d_addr(d_addr), .d_wdata(d_wdata), .d_wr_en(d_wr_en),
    .d_bytesel(d_bytesel), .d_rdata(d_rdata), .d_compl(d_compl),
    .m_cs(m_cs), .m_addr(m_addr), .m_wdata(m_wdata), .m_wr_en(m_wr_en),
    .m_bytesel(m_bytesel), .m_rdata(m_rdata), .m_compl(m_compl)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_pick_d();
    bit iv, dv;
    iv = i_cs && (i_bytesel != 4'b0000);
    dv = d_cs && (d_bytesel != 4'b0000);
    if (iv && dv) begin
`ifdef ARB_ROUND_ROBIN_EN
      return !last_d;
`else
      return 1'b1;
`endif
    end
    return dv;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m_cs"}, m_cs, 0);
    chk({tag, "_m_addr"}, m_addr, 0);
    chk({tag, "_m_wdata"}, m_wdata, 0);
    chk({tag, "_m_wr_en"}, m_wr_en, 0);
    chk({tag, "_m_bytesel"}, m_bytesel, 0);
    chk({tag, "_i_compl"}, i_compl, 0);
    chk({tag, "_d_compl"}, d_compl, 0);
    chk({tag, "_i_rdata"}, i_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
  endtask

  // One grant-to-release transaction; entered at a negedge with the arbiter about to sample in IDLE.
  task automatic txn(input int hold, input logic [31:0] rd);
    bit            wd;
    logic [AW-1:0] ea;
    logic [31:0]   ew;
    logic          ewr;
    logic [3:0]    eb;
    wd  = model_pick_d();
    ea  = wd ? d_addr : i_addr;
    ew  = wd ? d_wdata : i_wdata;
    ewr = wd ? d_wr_en : i_wr_en;
    eb  = wd ? d_bytesel : i_bytesel;
    last_d = wd;
    @(posedge clk);
    @(negedge clk);
    chk("grant_cs", m_cs, 1);
    chk("grant_addr", m_addr, ea);
    chk("grant_wdata", m_wdata, ew);
    chk("grant_wr_en", m_wr_en, ewr);
    chk("grant_bytesel", m_bytesel, eb);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_cs", m_cs, 1);
      chk("hold_addr", m_addr, ea);
      chk("hold_wdata", m_wdata, ew);
      chk("hold_wr_en", m_wr_en, ewr);
      chk("hold_bytesel", m_bytesel, eb);
      chk("hold_compl", {i_compl, d_compl}, 0);
    end
    m_compl = 1'b1;
    m_rdata = rd;
    @(negedge clk);
    m_compl = 1'b0;
    if (!ewr) begin
      if (wd) exp_drdata = rd;
      else exp_irdata = rd;
    end
    chk("rel_cs", m_cs, 0);
    chk("rel_bytesel", m_bytesel, 0);
    chk("rel_i_compl", i_compl, !wd);
    chk("rel_d_compl", d_compl, wd);
    chk("rel_i_rdata", i_rdata, exp_irdata);
    chk("rel_d_rdata", d_rdata, exp_drdata);
    if (wd) d_cs = 1'b0;
    else i_cs = 1'b0;
    @(negedge clk);
    chk("post_compl", {i_compl, d_compl}, 0);
    chk("post_cs", m_cs, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    i_cs = 0; i_addr = '0; i_wdata = '0; i_wr_en = 0; i_bytesel = '0;
    d_cs = 0; d_addr = '0; d_wdata = '0; d_wr_en = 0; d_bytesel = '0;
    m_compl = 0; m_rdata = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // D read alone
    d_cs = 1; d_addr = 32'h100; d_wr_en = 0; d_bytesel = 4'hF; d_wdata = 32'h0;
    txn(2, 32'hDEADBEEF);
    chk("d_read_value", d_rdata, 32'hDEADBEEF);
    chk("d_read_irdata", i_rdata, 32'h0);

    // I write: i_rdata must stay put
    i_cs = 1; i_addr = 32'h40; i_wdata = 32'h12345678; i_wr_en = 1; i_bytesel = 4'h3;
    txn(3, 32'hA5A5A5A5);
    chk("i_write_irdata", i_rdata, 32'h0);

    // Stray m_compl in IDLE plus a zero-bytesel select
    i_cs = 1; i_bytesel = 4'h0; i_wr_en = 0;
    m_compl = 1; m_rdata = 32'hCAFEF00D;
    @(negedge clk);
    m_compl = 0;
    chk("stray_cs", m_cs, 0);
    chk("stray_compl", {i_compl, d_compl}, 0);
    @(negedge clk);
    chk("ignored_cs", m_cs, 0);
    chk("ignored_i_rdata", i_rdata, exp_irdata);
    chk("ignored_d_rdata", d_rdata, exp_drdata);
    i_cs = 0;

    // Repeated ties: the loser keeps requesting, the winner re-requests right after release
    i_cs = 1; i_addr = 32'h1000; i_wdata = 32'h11; i_wr_en = 0; i_bytesel = 4'hF;
    d_cs = 1; d_addr = 32'h2000; d_wdata = 32'h22; d_wr_en = 0; d_bytesel = 4'hC;
    for (int t = 0; t < 4; t++) begin
      txn(t % 2, $urandom);
      i_cs = 1;
      d_cs = 1;
    end
    txn(0, $urandom);
    txn(0, $urandom);
    i_cs = 0; d_cs = 0;

    // Randomized traffic, masters hold pending requests until served
    for (int n = 0; n < 60; n++) begin
      if (!(i_cs && i_bytesel != 4'b0000)) begin
        i_cs = ($urandom_range(0, 3) != 0);
        i_addr = $urandom; i_wdata = $urandom; i_wr_en = $urandom_range(0, 1);
        i_bytesel = 4'($urandom_range(0, 15));
      end
      if (!(d_cs && d_bytesel != 4'b0000)) begin
        d_cs = ($urandom_range(0, 3) != 0);
        d_addr = $urandom; d_wdata = $urandom; d_wr_en = $urandom_range(0, 1);
        d_bytesel = 4'($urandom_range(0, 15));
      end
      if ((i_cs && i_bytesel != 4'b0000) || (d_cs && d_bytesel != 4'b0000)) begin
        txn($urandom_range(0, 3), $urandom);
      end else begin
        @(negedge clk);
        chk("rand_idle_cs", m_cs, 0);
        chk("rand_idle_compl", {i_compl, d_compl}, 0);
        i_cs = 0; d_cs = 0;
      end
    end

    // Reset during a D grant, then a stray completion
    i_cs = 0;
    d_cs = 1; d_addr = 32'h200; d_wr_en = 0; d_bytesel = 4'hF;
    @(posedge clk);
    @(negedge clk);
    chk("pre_reset_cs", m_cs, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    exp_irdata = '0; exp_drdata = '0; last_d = 1'b1;
    d_cs = 0;
    @(negedge clk);
    rst_n = 1'b1;
    m_compl = 1; m_rdata = 32'hBADBAD00;
    @(negedge clk);
    m_compl = 0;
    chk("after_reset_compl", {i_compl, d_compl}, 0);
    chk("after_reset_cs", m_cs, 0);
    @(negedge clk);
    chk_all_zero("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
